// File: rtl/imm_enc.sv
// imm_enc: splits a 32-bit constant into (imm, EOp) beats for the immediate extender.
// Define IMM_ENC_FAST_EN to test all four candidates in one SCAN cycle instead of one per cycle.
module imm_enc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic [1:0]       out_eop,
  output logic             out_last,
  output logic [CNT_W-1:0] split_cnt
);
  typedef enum logic [2:0] {IDLE, SCAN, EMIT, EMIT_HI, EMIT_LO} state_t;
  state_t state_q, state_d;
  logic [31:0] v_q, v_d;
  logic [1:0] idx_q, idx_d, eop_q, eop_d, sel_idx;
  logic [15:0] imm_q, imm_d, sel_imm;
  logic last_q, last_d, sel_hit, last_try;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] hit;
  always_comb begin
    hit[0] = &v_q[31:15] | ~|v_q[31:15];
    hit[1] = ~|v_q[31:16];
    hit[2] = ~|v_q[15:0];
    hit[3] = ~|v_q[1:0] & (&v_q[31:17] | ~|v_q[31:17]);
`ifdef IMM_ENC_FAST_EN
    sel_hit  = |hit;
    sel_idx  = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    last_try = 1'b1;
`else
    sel_hit  = hit[idx_q];
    sel_idx  = idx_q;
    last_try = idx_q == 2'd3;
`endif
    sel_imm = sel_idx == 2'd2 ? v_q[31:16] : sel_idx == 2'd3 ? v_q[17:2] : v_q[15:0];
  end
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    idx_d   = idx_q;
    imm_d   = imm_q;
    eop_d   = eop_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        v_d     = in_value;
        idx_d   = 2'd0;
        state_d = SCAN;
      end
      SCAN: if (sel_hit) begin
        imm_d   = sel_imm;
        eop_d   = sel_idx;
        last_d  = 1'b1;
        state_d = EMIT;
      end else if (last_try) begin
        imm_d   = v_q[31:16];
        eop_d   = 2'd2;
        last_d  = 1'b0;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
        state_d = EMIT_HI;
      end else begin
        idx_d = idx_q + 2'd1;
      end
      EMIT: if (out_ready) state_d = IDLE;
      EMIT_HI: if (out_ready) begin
        imm_d   = v_q[15:0];
        eop_d   = 2'd1;
        last_d  = 1'b1;
        state_d = EMIT_LO;
      end
      EMIT_LO: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      idx_q   <= '0;
      imm_q   <= '0;
      eop_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
      imm_q   <= imm_d;
      eop_q   <= eop_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == EMIT || state_q == EMIT_HI || state_q == EMIT_LO;
  assign out_imm   = imm_q;
  assign out_eop   = eop_q;
  assign out_last  = last_q;
  assign split_cnt = cnt_q;
endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed vectors for imm_enc, expected beats queued and checked by a monitor.
module tb_imm_enc;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_value = 0;
  logic in_ready, out_valid, out_last;
  logic [15:0] out_imm, split_cnt;
  logic [1:0] out_eop;
  typedef struct {logic [15:0] imm; logic [1:0] eop; logic last; int lat;} beat_t;
  beat_t sb[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  bit seen = 0, hold = 0;
  logic [18:0] held;

  imm_enc #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_eop(out_eop),
    .out_last(out_last), .split_cnt(split_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic int lat(input int k);
`ifdef IMM_ENC_FAST_EN
    return 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic push(input logic [15:0] imm, input logic [1:0] eop, input logic last, input int l);
    beat_t b;
    b.imm = imm; b.eop = eop; b.last = last; b.lat = l;
    sb.push_back(b);
  endtask

  always @(negedge clk) begin
    if (hold) chk("stable", {13'd0, out_imm, out_eop, out_last}, {13'd0, held});
    hold = 0;
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected beat got imm %h eop %0d want none", out_imm, out_eop);
      end else begin
        if (!seen && sb[0].lat >= 0) chk("latency", cyc - acc_cyc, sb[0].lat);
        seen = 1;
        if (out_ready) begin
          chk("imm", {16'd0, out_imm}, {16'd0, sb[0].imm});
          chk("eop", {30'd0, out_eop}, {30'd0, sb[0].eop});
          chk("last", {31'd0, out_last}, {31'd0, sb[0].last});
          void'(sb.pop_front());
          seen = 0;
        end else begin
          hold = 1;
          held = {out_imm, out_eop, out_last};
        end
      end
    end
  end

  task automatic send(input logic [31:0] v);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin checks++; errors++; $display("FAIL in_ready timeout got 0 want 1"); end
    in_valid = 1; in_value = v;
    @(posedge clk); #1;
    in_valid = 0; acc_cyc = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic one(input logic [31:0] v, input logic [15:0] imm, input logic [1:0] eop);
    push(imm, eop, 1'b1, lat(int'(eop)));
    send(v);
    drain();
  endtask

  task automatic reset_outputs();
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_imm", {16'd0, out_imm}, 32'd0);
    chk("rst out_eop", {30'd0, out_eop}, 32'd0);
    chk("rst out_last", {31'd0, out_last}, 32'd0);
    chk("rst split_cnt", {16'd0, split_cnt}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset_outputs();
    reset = 1;
    one(32'hFFFF_8000, 16'h8000, 2'd0);
    one(32'h0000_8000, 16'h8000, 2'd1);
    one(32'h1234_0000, 16'h1234, 2'd2);
    one(32'hFFFE_0004, 16'h8001, 2'd3);
    one(32'h0000_0000, 16'h0000, 2'd0);
    one(32'hFFFF_FFFF, 16'hFFFF, 2'd0);
    one(32'h0001_0000, 16'h0001, 2'd2);
    out_ready = 0;
    push(16'h1234, 2'd2, 1'b0, lat(3));
    push(16'h5678, 2'd1, 1'b1, -1);
    send(32'h1234_5678);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    drain();
    chk("split_cnt one", {16'd0, split_cnt}, 32'd1);
    push(16'h0001, 2'd2, 1'b0, lat(3));
    push(16'h0001, 2'd1, 1'b1, -1);
    send(32'h0001_0001);
    drain();
    chk("split_cnt two", {16'd0, split_cnt}, 32'd2);
    send(32'h1234_5678);
    #2 reset = 0;
    #1 reset_outputs();
    @(posedge clk); #1 reset = 1;
    one(32'h0000_0001, 16'h0001, 2'd0);
    chk("split_cnt after reset", {16'd0, split_cnt}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
